nibbler_control: RTL and testbench

NIBBLER_CONTROL -- requirements
Module: nibbler_control

---
 rtl/nibbler_control.sv | 97 +++++++++
 tb/tb_nibbler_control.sv | 133 +++++++++++++
 2 files changed

// File: rtl/nibbler_control.sv
// rtl/nibbler_control.sv - Nibbler CPU control unit: fetch/exec/halt sequencer, instruction register, flags and strobe decode.
module nibbler_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr,
    input  logic [4:0] alu_result,
    output logic [7:0] ir,
    output logic       notLoadA,
    output logic       notIncPC,
    output logic       notLoadPC,
    output logic       notLoadOut,
    output logic       carry_flag,
    output logic       zero_flag,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        HALT  = 2'b10
    } state_t;

    localparam logic [3:0] OP_ADDI  = 4'h0;
    localparam logic [3:0] OP_SUBI  = 4'h1;
    localparam logic [3:0] OP_NANDI = 4'h2;
    localparam logic [3:0] OP_LDI   = 4'h3;
    localparam logic [3:0] OP_OUT   = 4'h4;
    localparam logic [3:0] OP_JC    = 4'h5;
    localparam logic [3:0] OP_JNC   = 4'h6;
    localparam logic [3:0] OP_JZ    = 4'h7;
    localparam logic [3:0] OP_JNZ   = 4'h8;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [3:0] OP_HLT   = 4'hF;

    state_t     state;
    logic [3:0] opcode;

    assign opcode = ir[7:4];
    assign phase  = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            ir         <= 8'h00;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    ir    <= instr;
                    state <= EXEC;
                end
                EXEC: begin
                    state <= (opcode == OP_HLT) ? HALT : FETCH;
                    case (opcode)
                        OP_ADDI, OP_SUBI, OP_NANDI: begin
                            carry_flag <= alu_result[4];
                            zero_flag  <= (alu_result[3:0] == 4'h0);
                        end
                        OP_LDI: zero_flag <= (alu_result[3:0] == 4'h0);
                        default: ;
                    endcase
                end
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    // Strobes decode straight from ir and flags so an async reset (state -> FETCH) releases them at once.
    always_comb begin
        notLoadA   = 1'b1;
        notIncPC   = 1'b1;
        notLoadPC  = 1'b1;
        notLoadOut = 1'b1;
        if (state == EXEC) begin
            case (opcode)
                OP_ADDI, OP_SUBI, OP_NANDI, OP_LDI: begin
                    notLoadA = 1'b0;
                    notIncPC = 1'b0;
                end
                OP_OUT: begin
                    notLoadOut = 1'b0;
                    notIncPC   = 1'b0;
                end
                OP_JC:  begin notLoadPC = ~carry_flag; notIncPC =  carry_flag; end
                OP_JNC: begin notLoadPC =  carry_flag; notIncPC = ~carry_flag; end
                OP_JZ:  begin notLoadPC = ~zero_flag;  notIncPC =  zero_flag;  end
                OP_JNZ: begin notLoadPC =  zero_flag;  notIncPC = ~zero_flag;  end
                OP_JMP: notLoadPC = 1'b0;
                OP_HLT: ;
                default: notIncPC = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_nibbler_control.sv
// tb/tb_nibbler_control.sv - Directed self-checking bench for nibbler_control.
module tb_nibbler_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] instr;
    logic [4:0] alu_result;
    logic [7:0] ir;
    logic       notLoadA, notIncPC, notLoadPC, notLoadOut;
    logic       carry_flag, zero_flag;
    logic [1:0] phase;

    int n_cmp = 0;
    int n_err = 0;

    nibbler_control dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .alu_result (alu_result),
        .ir         (ir),
        .notLoadA   (notLoadA),
        .notIncPC   (notIncPC),
        .notLoadPC  (notLoadPC),
        .notLoadOut (notLoadOut),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Strobe vector {notLoadA, notIncPC, notLoadPC, notLoadOut}
    task automatic chk_strobes(input string tag, input logic [3:0] exp);
        chk({tag, "_strobes"}, {4'h0, notLoadA, notIncPC, notLoadPC, notLoadOut}, {4'h0, exp});
    endtask

    task automatic chk_state(input string tag, input logic [1:0] ph, input logic c, input logic z);
        chk({tag, "_phase"}, {6'h0, phase}, {6'h0, ph});
        chk({tag, "_flags"}, {6'h0, carry_flag, zero_flag}, {6'h0, c, z});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one instruction: after the first edge we are in EXEC, after the second back in FETCH.
    task automatic run(input string tag, input logic [7:0] i, input logic [4:0] a,
                       input logic [3:0] exp_strb, input logic c, input logic z);
        instr = i;
        alu_result = a;
        step();
        chk({tag, "_ir"}, ir, i);
        chk_state({tag, "_exec"}, 2'b01, carry_flag, zero_flag);
        chk_strobes({tag, "_exec"}, exp_strb);
        step();
        chk_state({tag, "_done"}, 2'b00, c, z);
        chk_strobes({tag, "_fetch"}, 4'b1111);
    endtask

    initial begin
        reset = 1'b1;
        instr = 8'h05;
        alu_result = 5'b00101;
        #3;
        chk("reset_ir", ir, 8'h00);
        chk_state("reset", 2'b00, 1'b0, 1'b0);
        chk_strobes("reset", 4'b1111);
        @(negedge clk);
        reset = 1'b0;

        run("addi5",  8'h05, 5'b00101, 4'b0011, 1'b0, 1'b0);
        run("subi",   8'h12, 5'b10000, 4'b0011, 1'b1, 1'b1);
        run("jz_tk",  8'h73, 5'b00111, 4'b1101, 1'b1, 1'b1);
        run("addi_c0",8'h01, 5'b00101, 4'b0011, 1'b0, 1'b0);
        run("jz_nt",  8'h73, 5'b00000, 4'b1011, 1'b0, 1'b0);
        run("jnz_tk", 8'h84, 5'b00000, 4'b1101, 1'b0, 1'b0);
        run("nandi",  8'h2F, 5'b10011, 4'b0011, 1'b1, 1'b0);
        run("jnc_nt", 8'h62, 5'b00000, 4'b1011, 1'b1, 1'b0);
        run("jc_tk",  8'h5E, 5'b00000, 4'b1101, 1'b1, 1'b0);
        run("ldi_z1", 8'h30, 5'b00000, 4'b0011, 1'b1, 1'b1);
        run("ldi",    8'h3A, 5'b01010, 4'b0011, 1'b1, 1'b0);
        run("out",    8'h47, 5'b10000, 4'b1010, 1'b1, 1'b0);
        run("jmp",    8'h95, 5'b10000, 4'b1101, 1'b1, 1'b0);
        run("nop",    8'hC3, 5'b10000, 4'b1011, 1'b1, 1'b0);

        // Reset in the middle of EXEC of an ADDI that would otherwise set both flags
        instr = 8'h05;
        alu_result = 5'b10000;
        step();
        chk_strobes("midrst_pre", 4'b0011);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_ir", ir, 8'h00);
        chk_state("midrst", 2'b00, 1'b0, 1'b0);
        chk_strobes("midrst", 4'b1111);
        @(posedge clk);
        #1;
        chk_state("midrst_hold", 2'b00, 1'b0, 1'b0);
        reset = 1'b0;
        run("post_rst", 8'h05, 5'b00101, 4'b0011, 1'b0, 1'b0);

        // Set C=1 then halt; HALT must ignore all inputs
        run("pre_hlt", 8'h01, 5'b10001, 4'b0011, 1'b1, 1'b0);
        instr = 8'hF0;
        alu_result = 5'b00000;
        step();
        chk("hlt_ir", ir, 8'hF0);
        chk_strobes("hlt_exec", 4'b1111);
        for (int k = 0; k < 10; k++) begin
            instr = 8'h10 * k[7:0] + 8'h01;
            alu_result = 5'(k * 3);
            step();
            chk_state("halt", 2'b10, 1'b1, 1'b0);
            chk("halt_ir", ir, 8'hF0);
            chk_strobes("halt", 4'b1111);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
